// File: rtl/de_ex_stage_if.sv
`default_nettype none
// ============================================================================
// de_ex_stage_if : Decode->Execute bundle (decode fields in, execute fields out)
// Revision 1.0
// ============================================================================
interface de_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            ALUASrc_de, ALUBSrc_de, DMWr_de, RUWr_de;
  logic [1:0]      RuDataWrSrc_de;
  logic [2:0]      DMCtrl_de;
  logic [3:0]      ALUOp_de;
  logic [4:0]      BrOp_de;
  logic [XLEN-1:0] PC_de, PCInc_de, RUrs1_de, RUrs2_de, ImmExt_de;
  logic [4:0]      rs1_de, rs2_de, rd_de;
  logic            flush_ex;

  logic            ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex;
  logic [1:0]      RuDataWrSrc_ex;
  logic [2:0]      DMCtrl_ex;
  logic [3:0]      ALUOp_ex;
  logic [4:0]      BrOp_ex;
  logic [XLEN-1:0] PC_ex, PCInc_ex, RUrs1_ex, RUrs2_ex, ImmExt_ex;
  logic [4:0]      rs1_ex, rs2_ex, rd_ex;
  logic            valid_ex;
  logic            stall_fd;

  modport master (
    output ALUASrc_de, ALUBSrc_de, DMWr_de, RUWr_de, RuDataWrSrc_de, DMCtrl_de,
           ALUOp_de, BrOp_de, PC_de, PCInc_de, RUrs1_de, RUrs2_de, ImmExt_de,
           rs1_de, rs2_de, rd_de, flush_ex,
    input  ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex, RuDataWrSrc_ex, DMCtrl_ex,
           ALUOp_ex, BrOp_ex, PC_ex, PCInc_ex, RUrs1_ex, RUrs2_ex, ImmExt_ex,
           rs1_ex, rs2_ex, rd_ex, valid_ex, stall_fd
  );

  modport slave (
    input  ALUASrc_de, ALUBSrc_de, DMWr_de, RUWr_de, RuDataWrSrc_de, DMCtrl_de,
           ALUOp_de, BrOp_de, PC_de, PCInc_de, RUrs1_de, RUrs2_de, ImmExt_de,
           rs1_de, rs2_de, rd_de, flush_ex,
    output ALUASrc_ex, ALUBSrc_ex, DMWr_ex, RUWr_ex, RuDataWrSrc_ex, DMCtrl_ex,
           ALUOp_ex, BrOp_ex, PC_ex, PCInc_ex, RUrs1_ex, RUrs2_ex, ImmExt_ex,
           rs1_ex, rs2_ex, rd_ex, valid_ex, stall_fd
  );
endinterface
`default_nettype wire

// File: rtl/de_ex_stage.sv
`default_nettype none
// ============================================================================
// de_ex_stage : DE->EX pipeline register with load-use stall and flush bubble
// Revision 1.0
// ============================================================================
module de_ex_stage #(
  parameter int XLEN = 32
) (
  input  wire            clk,
  input  wire            rst_n,
  de_ex_stage_if.slave   bus
);

  logic            r_alua_src, r_alub_src, r_dm_wr, r_ru_wr, r_valid;
  logic [1:0]      r_ru_data_wr_src;
  logic [2:0]      r_dm_ctrl;
  logic [3:0]      r_alu_op;
  logic [4:0]      r_br_op;
  logic [XLEN-1:0] r_pc, r_pc_inc, r_rurs1, r_rurs2, r_imm_ext;
  logic [4:0]      r_rs1, r_rs2, r_rd;

  logic w_load_use;
  logic w_take;

  // Conservative: rs1/rs2 are compared whether or not the instruction reads them.
  assign w_load_use = r_valid && (r_ru_data_wr_src == 2'b01) && (r_rd != 5'd0) &&
                      ((r_rd == bus.rs1_de) || (r_rd == bus.rs2_de));
  assign w_take     = !bus.flush_ex && !w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alua_src       <= 1'b0;
      r_alub_src       <= 1'b0;
      r_dm_wr          <= 1'b0;
      r_ru_wr          <= 1'b0;
      r_ru_data_wr_src <= 2'b00;
      r_dm_ctrl        <= 3'b000;
      r_alu_op         <= 4'b0000;
      r_br_op          <= 5'b00000;
      r_pc             <= '0;
      r_pc_inc         <= '0;
      r_rurs1          <= '0;
      r_rurs2          <= '0;
      r_imm_ext        <= '0;
      r_rs1            <= 5'd0;
      r_rs2            <= 5'd0;
      r_rd             <= 5'd0;
      r_valid          <= 1'b0;
    end else begin
      // A bubble is the all-zero word, so it can never retrigger load_use.
      r_alua_src       <= w_take ? bus.ALUASrc_de     : 1'b0;
      r_alub_src       <= w_take ? bus.ALUBSrc_de     : 1'b0;
      r_dm_wr          <= w_take ? bus.DMWr_de        : 1'b0;
      r_ru_wr          <= w_take ? bus.RUWr_de        : 1'b0;
      r_ru_data_wr_src <= w_take ? bus.RuDataWrSrc_de : 2'b00;
      r_dm_ctrl        <= w_take ? bus.DMCtrl_de      : 3'b000;
      r_alu_op         <= w_take ? bus.ALUOp_de       : 4'b0000;
      r_br_op          <= w_take ? bus.BrOp_de        : 5'b00000;
      r_pc             <= w_take ? bus.PC_de          : '0;
      r_pc_inc         <= w_take ? bus.PCInc_de       : '0;
      r_rurs1          <= w_take ? bus.RUrs1_de       : '0;
      r_rurs2          <= w_take ? bus.RUrs2_de       : '0;
      r_imm_ext        <= w_take ? bus.ImmExt_de      : '0;
      r_rs1            <= w_take ? bus.rs1_de         : 5'd0;
      r_rs2            <= w_take ? bus.rs2_de         : 5'd0;
      r_rd             <= w_take ? bus.rd_de          : 5'd0;
      r_valid          <= w_take;
    end
  end

  assign bus.ALUASrc_ex     = r_alua_src;
  assign bus.ALUBSrc_ex     = r_alub_src;
  assign bus.DMWr_ex        = r_dm_wr;
  assign bus.RUWr_ex        = r_ru_wr;
  assign bus.RuDataWrSrc_ex = r_ru_data_wr_src;
  assign bus.DMCtrl_ex      = r_dm_ctrl;
  assign bus.ALUOp_ex       = r_alu_op;
  assign bus.BrOp_ex        = r_br_op;
  assign bus.PC_ex          = r_pc;
  assign bus.PCInc_ex       = r_pc_inc;
  assign bus.RUrs1_ex       = r_rurs1;
  assign bus.RUrs2_ex       = r_rurs2;
  assign bus.ImmExt_ex      = r_imm_ext;
  assign bus.rs1_ex         = r_rs1;
  assign bus.rs2_ex         = r_rs2;
  assign bus.rd_ex          = r_rd;
  assign bus.valid_ex       = r_valid;
  // A flush discards the load's dependent anyway, so there is nothing to hold.
  assign bus.stall_fd       = w_load_use && !bus.flush_ex;

endmodule
`default_nettype wire

// File: tb/tb_de_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_de_ex_stage : directed + random bench for de_ex_stage against a stage model
// Revision 1.0
// ============================================================================
module tb_de_ex_stage;

  localparam int XLEN = 32;

  typedef struct packed {
    logic            alua, alub, dmwr, ruwr;
    logic [1:0]      wsrc;
    logic [2:0]      dmctrl;
    logic [3:0]      aluop;
    logic [4:0]      brop;
    logic [XLEN-1:0] pc, pcinc, rurs1, rurs2, imm;
    logic [4:0]      rs1, rs2, rd;
  } instr_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   flush = 1'b0;
  instr_t de = '0;
  instr_t obs;

  // Stage model: what Execute should hold, and whether it is a real instruction.
  instr_t m_ex = '0;
  bit     m_valid = 1'b0;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  de_ex_stage_if #(.XLEN(XLEN)) bus ();
  de_ex_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  assign bus.ALUASrc_de     = de.alua;
  assign bus.ALUBSrc_de     = de.alub;
  assign bus.DMWr_de        = de.dmwr;
  assign bus.RUWr_de        = de.ruwr;
  assign bus.RuDataWrSrc_de = de.wsrc;
  assign bus.DMCtrl_de      = de.dmctrl;
  assign bus.ALUOp_de       = de.aluop;
  assign bus.BrOp_de        = de.brop;
  assign bus.PC_de          = de.pc;
  assign bus.PCInc_de       = de.pcinc;
  assign bus.RUrs1_de       = de.rurs1;
  assign bus.RUrs2_de       = de.rurs2;
  assign bus.ImmExt_de      = de.imm;
  assign bus.rs1_de         = de.rs1;
  assign bus.rs2_de         = de.rs2;
  assign bus.rd_de          = de.rd;
  assign bus.flush_ex       = flush;

  assign obs = {bus.ALUASrc_ex, bus.ALUBSrc_ex, bus.DMWr_ex, bus.RUWr_ex,
                bus.RuDataWrSrc_ex, bus.DMCtrl_ex, bus.ALUOp_ex, bus.BrOp_ex,
                bus.PC_ex, bus.PCInc_ex, bus.RUrs1_ex, bus.RUrs2_ex, bus.ImmExt_ex,
                bus.rs1_ex, bus.rs2_ex, bus.rd_ex};

  task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t r;
    r.alua   = 1'($urandom);
    r.alub   = 1'($urandom);
    r.dmwr   = 1'($urandom);
    r.ruwr   = 1'($urandom);
    r.wsrc   = 2'($urandom_range(0, 2));
    r.dmctrl = 3'($urandom);
    r.aluop  = 4'($urandom);
    r.brop   = 5'($urandom);
    r.pc     = $urandom;
    r.pcinc  = r.pc + 32'd4;
    r.rurs1  = $urandom;
    r.rurs2  = $urandom;
    r.imm    = $urandom;
    r.rs1    = 5'($urandom_range(0, 7));
    r.rs2    = 5'($urandom_range(0, 7));
    r.rd     = 5'($urandom_range(0, 7));
    return r;
  endfunction

  // A load in EX stalls a reader of its destination, unless it targets x0.
  function automatic bit hazard(instr_t ex, bit v, instr_t d);
    return v && ex.wsrc == 2'b01 && ex.rd != 5'd0 && (ex.rd == d.rs1 || ex.rd == d.rs2);
  endfunction

  // Called at a falling edge with de/flush already driven; returns whether it stalled.
  task automatic cycle(input string tag, output bit stalled);
    bit hz;
    hz = hazard(m_ex, m_valid, de);
    stalled = hz && !flush;
    #1;
    check({tag, ".stall_fd"}, 256'(bus.stall_fd), 256'(stalled));
    @(posedge clk);
    if (flush || hz) begin
      m_ex = '0;
      m_valid = 1'b0;
    end else begin
      m_ex = de;
      m_valid = 1'b1;
    end
    #1;
    check({tag, ".fields"}, 256'(obs), 256'(m_ex));
    check({tag, ".valid_ex"}, 256'(bus.valid_ex), 256'(m_valid));
    @(negedge clk);
  endtask

  initial begin
    bit st;
    instr_t ld;

    // Reset held across a clock edge with arbitrary decode contents.
    de = rand_instr();
    @(negedge clk);
    @(posedge clk);
    #1;
    check("rst.fields", 256'(obs), 256'(0));
    check("rst.valid_ex", 256'(bus.valid_ex), 256'(0));
    check("rst.stall_fd", 256'(bus.stall_fd), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    de.aluop = 4'b0101;
    cycle("rst_release", st);
    check("rst_release.aluop", 256'(bus.ALUOp_ex), 256'(4'b0101));

    // R-type pass-through.
    de = '0;
    de.ruwr = 1'b1; de.aluop = 4'b1000; de.rd = 5'd5; de.pc = 32'h40;
    de.rs1 = 5'd1; de.rs2 = 5'd2;
    cycle("rtype", st);
    check("rtype.pc", 256'(bus.PC_ex), 256'(32'h40));
    check("rtype.rd", 256'(bus.rd_ex), 256'(5));

    // lw x6, then a dependent add: exactly one bubble.
    ld = '0;
    ld.ruwr = 1'b1; ld.wsrc = 2'b01; ld.dmctrl = 3'b010; ld.rd = 5'd6; ld.pc = 32'h44;
    de = ld;
    cycle("lw6", st);
    de = '0;
    de.ruwr = 1'b1; de.rs1 = 5'd1; de.rs2 = 5'd6; de.rd = 5'd7; de.pc = 32'h48;
    cycle("lu_bubble", st);
    check("lu_bubble.stalled", 256'(st), 256'(1));
    check("lu_bubble.ruwr", 256'(bus.RUWr_ex), 256'(0));
    cycle("lu_advance", st);
    check("lu_advance.rd", 256'(bus.rd_ex), 256'(7));

    // Load to x0 never stalls.
    ld.rd = 5'd0;
    de = ld;
    cycle("lw0", st);
    de = '0;
    de.rs1 = 5'd0; de.rs2 = 5'd3; de.rd = 5'd4; de.pc = 32'h50;
    cycle("lw0_dep", st);
    check("lw0_dep.valid", 256'(bus.valid_ex), 256'(1));

    // Flush beats load-use in the same cycle.
    ld.rd = 5'd6;
    de = ld;
    cycle("lw6b", st);
    de = '0;
    de.rs1 = 5'd6; de.brop = 5'b10101; de.rd = 5'd9;
    flush = 1'b1;
    cycle("flush_over_stall", st);
    check("flush.brop", 256'(bus.BrOp_ex), 256'(0));
    flush = 1'b0;

    // Store in EX, then an asynchronous reset between edges.
    de = '0;
    de.dmwr = 1'b1; de.dmctrl = 3'b010; de.rs1 = 5'd2; de.rs2 = 5'd3; de.pc = 32'h60;
    cycle("store", st);
    check("store.dmwr", 256'(bus.DMWr_ex), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.dmwr", 256'(bus.DMWr_ex), 256'(0));
    check("async_rst.valid", 256'(bus.valid_ex), 256'(0));
    m_ex = '0;
    m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    de = rand_instr();
    cycle("post_rst", st);

    // Random traffic; a stalled instruction is re-presented unchanged.
    st = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!st) de = rand_instr();
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand", st);
    end
    flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/de_ex_stage.md
Name: de_ex_stage

Overview:
- Decode→Execute pipeline register of the 5-stage RISC-V core, directly downstream of the control unit.
- Captures every decode-stage control field (*_de) plus operands, PCs, immediate and register indices, and presents them registered as *_ex.
- Contains load-use hazard detection: stalls fetch/decode and injects a bubble.
- Accepts a branch/jump flush from Execute.

Parameters:
XLEN, 32, datapath width (PC, operands, immediate)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ALUASrc_de  in  1  CU control field
ALUBSrc_de  in  1  CU control field
DMWr_de  in  1  CU control field
RUWr_de  in  1  CU control field
RuDataWrSrc_de  in  2  CU control field (00 ALU, 01 memory, 10 PC+4)
DMCtrl_de  in  3  CU control field
ALUOp_de  in  4  CU control field
BrOp_de  in  5  CU control field
PC_de, PCInc_de, RUrs1_de, RUrs2_de, ImmExt_de  in  XLEN each  decode data
rs1_de, rs2_de, rd_de  in  5 each  register indices of the instruction in Decode
flush_ex  in  1  taken branch/jump resolved in Execute
ALUASrc_ex … BrOp_ex  out  same widths as *_de  registered control
PC_ex, PCInc_ex, RUrs1_ex, RUrs2_ex, ImmExt_ex  out  XLEN each  registered data
rs1_ex, rs2_ex, rd_ex  out  5 each  registered indices (for forwarding unit)
valid_ex  out  1  Execute holds a real instruction
stall_fd  out  1  hold PC and IF/DE register this cycle

Behaviour:
- Reset (rst_n=0, async, immediate): all *_ex outputs 0, valid_ex=0. stall_fd is combinational and reads 0 because RuDataWrSrc_ex=00.
- load_use (combinational) = valid_ex & (RuDataWrSrc_ex==2'b01) & (rd_ex!=0) & ((rd_ex==rs1_de) | (rd_ex==rs2_de)).
  - The comparison is conservative: it does not qualify on whether the decoded instruction uses rs1/rs2.
- stall_fd = load_use & ~flush_ex.
- On each clk rising edge, priority order:
  1. flush_ex=1: load bubble (all *_ex fields 0, valid_ex=0). Flush overrides load_use.
  2. load_use=1: load bubble. Decode contents are retained upstream via stall_fd and re-presented next cycle.
  3. Otherwise: capture all *_de into *_ex, valid_ex=1.
- Bubble = all-zero control (RUWr=0, DMWr=0, BrOp=00000, RuDataWrSrc=00) and all-zero data/indices.
  - A bubble can never retrigger load_use because valid_ex=0 and rd_ex=0.
- Latency: exactly 1 cycle from *_de to *_ex; no internal buffering beyond one entry.
- A load followed by a dependent instruction costs exactly one bubble. The next cycle the load has left EX, so load_use drops and the dependent instruction advances.
- Back-to-back loads where the 2nd depends on the 1st: one bubble, same rule.
- rd_ex==0 (load to x0): never a stall.
- Reset asserted mid-stall: outputs clear asynchronously. After release, normal capture resumes on the first edge.
- No X propagation: every register has a defined reset and a defined next value in every branch.

Test Plan:
- Reset: hold rst_n=0, drive arbitrary *_de -> all *_ex=0, valid_ex=0, stall_fd=0. Release -> next edge captures ALUOp_de=4'b0101 into ALUOp_ex, valid_ex=1.
- Pass-through: R-type (RUWr_de=1, ALUOp_de=4'b1000, rd_de=5, PC_de=0x40) -> one edge later RUWr_ex=1, ALUOp_ex=1000, rd_ex=5, PC_ex=0x40.
- Load-use: lw x6 in EX (RuDataWrSrc_ex=01, rd_ex=6), add with rs2_de=6 in DE -> stall_fd=1 for one cycle, bubble (valid_ex=0, RUWr_ex=0). Next edge captures the add, stall_fd=0.
- Load to x0: RuDataWrSrc_ex=01, rd_ex=0, rs1_de=0 -> stall_fd=0, normal capture.
- Flush over stall: load_use condition true and flush_ex=1 in the same cycle -> stall_fd=0, bubble loaded, BrOp_ex=0.
- Async reset mid-operation: assert rst_n low between edges while valid_ex=1, DMWr_ex=1 -> DMWr_ex and valid_ex drop to 0 without waiting for a clk edge.
